cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
// Parametrised coprocessor-0 and exception controller for the MIPS core. Merges per-stage
// exception codes by priority, samples STAGES-wide hardware interrupt lines plus an
// optional Count/Compare timer, and owns SR/Cause/EPC/PRId. Raises a one-cycle-decided
// req that redirects PC to the handler; eret returns via epc_out. Sits beside GRF/DM.
// PARAMETERS
// HW_INT_NUM  6           external interrupt lines, 1..6; mapped to IP[9+HW_INT_NUM:10]
// STAGES      4           number of pipeline stages reporting exception codes (F,D,E,M...)
// HAS_TIMER   1           1: Count/Compare present, timer irq drives IP[15] (overrides hw_int[5])
// PRID        32'h0000_4F50  read-only PRId value
// PORTS
// clk         in   1            rising-edge clock
// reset       in   1            asynchronous reset, active-low
// we          in   1            mtc0 write enable
// addr        in   5            CP0 register number for mtc0/mfc0
// wdata       in   32           mtc0 data
// rdata       out  32           mfc0 data, combinational on addr
// vpc         in   32           PC of the victim instruction
// bd_in       in   1            victim is in a branch delay slot
// exc_stage   in   STAGES*5     per-stage ExcCode, slice 0 = earliest stage; 0 = none
// hw_int      in   HW_INT_NUM   level-sensitive external interrupts
// eret        in   1            eret retiring this cycle
// req         out  1            take exception/interrupt this cycle
// epc_out     out  32           EPC value for eret/handler redirect
// exl_out     out  1            SR.EXL
// timer_irq   out  1            Count==Compare sticky flag (0 when HAS_TIMER=0)
// BEHAVIOUR
// - Registers: 9 Count, 11 Compare, 12 SR{IM[15:10],EXL[1],IE[0]}, 13 Cause{BD[31],
//   IP[15:10],ExcCode[6:2]}, 14 EPC, 15 PRId. Unlisted addr/bits read 0, writes ignored.
// - Reset (reset==0, async): SR=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF,
//   timer_irq=0; hence req=0, exl_out=0, epc_out=0.
// - exc_code = first nonzero slice scanning index 0 upward; else 0.
// - int_req = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL;  exc_req = (exc_code!=0) & !SR.EXL;
//   req = int_req | exc_req (combinational, same cycle). Interrupt beats exception.
// - On posedge with req: SR.EXL<=1; Cause.ExcCode<= int_req ? 0 : exc_code;
//   Cause.BD<=bd_in; EPC<= bd_in ? vpc-4 : vpc (32-bit wrap, no alignment fix).
// - Cause.IP resampled every posedge from hw_int/timer_irq regardless of req; bits above
//   HW_INT_NUM stay 0. Cause is read-only to mtc0.
// - mtc0: SR, EPC, Compare writable at posedge. Count writable when HAS_TIMER.
//   Writes masked to defined fields.
// - Same-cycle priority: req > eret > we. Write dropped if req=1; eret (clears EXL) with
//   req=1 is ignored (req path sets EXL).
// - Count increments every cycle (wraps 32'hFFFF_FFFF->0); Count write takes priority over
//   increment. timer_irq sets on posedge when Count==Compare, held until Compare written
//   (write clears it that cycle, even if equality still holds next cycle it re-arms).
// - rdata reflects pre-edge register values (no write-through bypass); epc_out = EPC.
// - reset asserted mid-handler: all state cleared immediately, no req issued until release.
// STRUCTURE
// - Shared package/include (constants.v): CP0 register numbers, ExcCode values (Int=0,
//   AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12), SR/Cause bit-field positions.
// - One sub-module: cp0_timer (Count/Compare/timer_irq), generated only when HAS_TIMER=1.
// - Priority scan over exc_stage as a generate/for loop; no latches.
// TESTING
// - Reset low mid-run -> rdata(12/13/14)=0, req=0, Compare reads 32'hFFFF_FFFF, Count restarts at 0.
// - exc_stage={M:12,E:0,D:10,F:0}, vpc=32'h3010, bd_in=1 -> req=1; next cycle EPC=32'h300C,
//   Cause=32'h8000_0028, SR.EXL=1; second exception while EXL=1 -> req=0.
// - SR=32'h0000_0401, hw_int[0]=1 plus exc_stage F=4 -> req=1, ExcCode=0 (interrupt wins).
// - Compare<=5 at Count=0 -> timer_irq at Count==5, IP[15]=1, req with IM[15]&IE; Compare
//   write clears timer_irq.
// - eret with EXL=1 -> EXL=0, epc_out unchanged; mtc0 SR with req=1 same cycle -> write lost.
// - HW_INT_NUM=2, HAS_TIMER=0, STAGES=5 build: Cause.IP[15:12]=0 always, Count reads 0.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR/Cause field layout.
// Also provides helpers that pack the SR and Cause fields into their 32-bit register images.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] RegCount   = 5'd9;
    localparam logic [4:0] RegCompare = 5'd11;
    localparam logic [4:0] RegSr      = 5'd12;
    localparam logic [4:0] RegCause   = 5'd13;
    localparam logic [4:0] RegEpc     = 5'd14;
    localparam logic [4:0] RegPrid    = 5'd15;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdel = 5'd4,
        ExcAdes = 5'd5,
        ExcSys  = 5'd8,
        ExcRi   = 5'd10,
        ExcOv   = 5'd12
    } exc_code_e;

    localparam int unsigned SrIeBit    = 0;
    localparam int unsigned SrExlBit   = 1;
    localparam int unsigned SrImLo     = 10;
    localparam int unsigned CauseExcLo = 2;
    localparam int unsigned CauseIpLo  = 10;
    localparam int unsigned CauseBdBit = 31;

    localparam logic [31:0] CompareRst = 32'hFFFF_FFFF;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v               = '0;
        v[SrImLo +: 6]  = im;
        v[SrExlBit]     = exl;
        v[SrIeBit]      = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v                  = '0;
        v[CauseBdBit]      = bd;
        v[CauseIpLo +: 6]  = ip;
        v[CauseExcLo +: 5] = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count free-runs; timer_irq is a sticky equality flag that only a
// Compare write clears.
module cp0_timer
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_irq
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            compare_q <= CompareRst;
            irq_q     <= 1'b0;
        end else begin
            count_q <= count_we ? wdata : count_q + 32'd1;
            // Compare write wins over a same-cycle match so software can always acknowledge.
            if (compare_we) begin
                compare_q <= wdata;
                irq_q     <= 1'b0;
            end else if (count_q == compare_q) begin
                irq_q     <= 1'b1;
            end
        end
    end

    assign count     = count_q;
    assign compare   = compare_q;
    assign timer_irq = irq_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 and exception controller: priority-merges per-stage exception codes,
// samples interrupts, owns SR/Cause/EPC/PRId and decides req in the same cycle.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int unsigned HW_INT_NUM = 6,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned HAS_TIMER  = 1,
    parameter logic [31:0] PRID       = 32'h0000_4F50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [4:0]              addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    input  logic [31:0]             vpc,
    input  logic                    bd_in,
    input  logic [STAGES*5-1:0]     exc_stage,
    input  logic [HW_INT_NUM-1:0]   hw_int,
    input  logic                    eret,
    output logic                    req,
    output logic [31:0]             epc_out,
    output logic                    exl_out,
    output logic                    timer_irq
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [4:0]  exc_code;
    logic        int_req;
    logic        exc_req;
    logic        wr_ok;
    logic [31:0] count_w;
    logic [31:0] compare_w;
    logic        timer_irq_w;
    logic        unused_hw;

    // Scan from the latest stage down so the earliest nonzero slice is the last assignment.
    always_comb begin
        exc_code = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (exc_stage[i*5 +: 5] != 5'd0) begin
                exc_code = exc_stage[i*5 +: 5];
            end
        end
    end

    assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign exc_req = (exc_code != 5'd0) & ~exl_q;
    assign req     = reset & (int_req | exc_req);
    assign wr_ok   = we & ~req & ~eret;

    // Timer line overrides the top external line when the timer is present.
    always_comb begin
        ip_d = '0;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            ip_d[i] = hw_int[i];
        end
        if (HAS_TIMER != 0) begin
            ip_d[5] = timer_irq_w;
        end
    end
    assign unused_hw = ^hw_int;

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (req) begin
            exl_d     = 1'b1;
            exccode_d = int_req ? ExcInt : exc_code;
            bd_d      = bd_in;
            epc_d     = bd_in ? vpc - 32'd4 : vpc;
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (wr_ok) begin
            case (addr)
                RegSr: begin
                    im_d  = wdata[SrImLo +: 6];
                    exl_d = wdata[SrExlBit];
                    ie_d  = wdata[SrIeBit];
                end
                RegEpc:  epc_d = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    if (HAS_TIMER != 0) begin : g_timer
        cp0_timer u_timer (
            .clk        (clk),
            .reset      (reset),
            .count_we   (wr_ok && (addr == RegCount)),
            .compare_we (wr_ok && (addr == RegCompare)),
            .wdata      (wdata),
            .count      (count_w),
            .compare    (compare_w),
            .timer_irq  (timer_irq_w)
        );
    end else begin : g_no_timer
        assign count_w     = '0;
        assign compare_w   = '0;
        assign timer_irq_w = 1'b0;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            RegCount:   rdata = count_w;
            RegCompare: rdata = compare_w;
            RegSr:      rdata = pack_sr(im_q, exl_q, ie_q);
            RegCause:   rdata = pack_cause(bd_q, ip_q, exccode_q);
            RegEpc:     rdata = epc_q;
            RegPrid:    rdata = PRID;
            default:    rdata = '0;
        endcase
    end

    assign epc_out   = epc_q;
    assign exl_out   = exl_q;
    assign timer_irq = timer_irq_w;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: default build plus a small no-timer, five-stage build.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [19:0] exc_stage;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic        exl_out;
    logic        timer_irq;

    logic        s_we;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic [31:0] s_vpc;
    logic        s_bd;
    logic [24:0] s_exc;
    logic [1:0]  s_hw;
    logic        s_eret;
    logic        s_req;
    logic [31:0] s_epc;
    logic        s_exl;
    logic        s_tirq;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .vpc       (vpc),
        .bd_in     (bd_in),
        .exc_stage (exc_stage),
        .hw_int    (hw_int),
        .eret      (eret),
        .req       (req),
        .epc_out   (epc_out),
        .exl_out   (exl_out),
        .timer_irq (timer_irq)
    );

    cp0_exc_ctrl #(
        .HW_INT_NUM (2),
        .STAGES     (5),
        .HAS_TIMER  (0)
    ) u_small (
        .clk       (clk),
        .reset     (reset),
        .we        (s_we),
        .addr      (s_addr),
        .wdata     (s_wdata),
        .rdata     (s_rdata),
        .vpc       (s_vpc),
        .bd_in     (s_bd),
        .exc_stage (s_exc),
        .hw_int    (s_hw),
        .eret      (s_eret),
        .req       (s_req),
        .epc_out   (s_epc),
        .exl_out   (s_exl),
        .timer_irq (s_tirq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        tests_run++;
        if (req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %0b want 0", req); end
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL rst_sr: got %h want 0", d); end
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL rst_cause: got %h want 0", d); end
        rd(5'd11, d);
        tests_run++;
        if (d !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL rst_compare: got %h want ffffffff", d);
        end
        rd(5'd9, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL rst_count: got %h want 0", d); end
        reset = 1'b1;
        tick();
        tests_run++;
        if (exl_out !== 1'b0 || epc_out !== 32'h0 || timer_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_outs: got exl=%0b epc=%h tirq=%0b want 0/0/0",
                     exl_out, epc_out, timer_irq);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        rd(5'd15, d);
        tests_run++;
        if (d !== 32'h0000_4F50) begin tests_failed++; $display("FAIL prid: got %h want 4f50", d); end
        wr(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL cause_ro: got %h want 0", d); end
        wr(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h0000_FC03) begin tests_failed++; $display("FAIL sr_mask: got %h want fc03", d); end
        wr(5'd12, 32'h0);
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL sr_clear: got %h want 0", d); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        exc_stage = {5'd12, 5'd0, 5'd10, 5'd0};
        vpc       = 32'h0000_3010;
        bd_in     = 1'b1;
        #1;
        tests_run++;
        if (req !== 1'b1) begin tests_failed++; $display("FAIL exc_req: got %0b want 1", req); end
        tick();
        exc_stage = '0;
        bd_in     = 1'b0;
        rd(5'd14, d);
        tests_run++;
        if (d !== 32'h0000_300C) begin tests_failed++; $display("FAIL exc_epc: got %h want 300c", d); end
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h8000_0028) begin
            tests_failed++; $display("FAIL exc_cause: got %h want 80000028", d);
        end
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h2 || exl_out !== 1'b1) begin
            tests_failed++; $display("FAIL exc_sr: got %h exl=%0b want 2/1", d, exl_out);
        end
        exc_stage = 20'd4;
        #1;
        tests_run++;
        if (req !== 1'b0) begin tests_failed++; $display("FAIL exc_nested: got %0b want 0", req); end
        tick();
        exc_stage = '0;
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h8000_0028) begin
            tests_failed++; $display("FAIL exc_hold: got %h want 80000028", d);
        end
    endtask

    task automatic test_eret();
        logic [31:0] d;
        eret = 1'b1;
        #1;
        tests_run++;
        if (req !== 1'b0) begin tests_failed++; $display("FAIL eret_req: got %0b want 0", req); end
        tick();
        eret = 1'b0;
        rd(5'd12, d);
        tests_run++;
        if (exl_out !== 1'b0 || d !== 32'h0 || epc_out !== 32'h0000_300C) begin
            tests_failed++;
            $display("FAIL eret: got exl=%0b sr=%h epc=%h want 0/0/300c", exl_out, d, epc_out);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        hw_int = 6'b000001;
        wr(5'd12, 32'h0000_0401);
        exc_stage = 20'd4;
        vpc       = 32'h0000_4000;
        bd_in     = 1'b0;
        #1;
        tests_run++;
        if (req !== 1'b1) begin tests_failed++; $display("FAIL int_req: got %0b want 1", req); end
        tick();
        exc_stage = '0;
        hw_int    = '0;
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0000_0400) begin tests_failed++; $display("FAIL int_cause: got %h want 400", d); end
        rd(5'd14, d);
        tests_run++;
        if (d !== 32'h0000_4000) begin tests_failed++; $display("FAIL int_epc: got %h want 4000", d); end
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h0000_0403) begin tests_failed++; $display("FAIL int_sr: got %h want 403", d); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tests_run++;
        if (req !== 1'b0 || exl_out !== 1'b0) begin
            tests_failed++; $display("FAIL int_eret: got req=%0b exl=%0b want 0/0", req, exl_out);
        end
    endtask

    task automatic test_write_lost();
        logic [31:0] d;
        exc_stage = 20'd4;
        vpc       = 32'h0000_5000;
        bd_in     = 1'b0;
        we        = 1'b1;
        addr      = 5'd12;
        wdata     = 32'h0000_FC01;
        #1;
        tests_run++;
        if (req !== 1'b1) begin tests_failed++; $display("FAIL wl_req: got %0b want 1", req); end
        tick();
        we        = 1'b0;
        exc_stage = '0;
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h0000_0403) begin tests_failed++; $display("FAIL wl_sr: got %h want 403", d); end
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0000_0010) begin tests_failed++; $display("FAIL wl_cause: got %h want 10", d); end
        rd(5'd14, d);
        tests_run++;
        if (d !== 32'h0000_5000) begin tests_failed++; $display("FAIL wl_epc: got %h want 5000", d); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_timer();
        logic [31:0] d;
        wr(5'd12, 32'h0000_8001);
        wr(5'd9, 32'h0);
        wr(5'd11, 32'h5);
        rd(5'd9, d);
        tests_run++;
        if (d !== 32'h1) begin tests_failed++; $display("FAIL tmr_count: got %h want 1", d); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (timer_irq !== 1'b0) begin
                tests_failed++; $display("FAIL tmr_early[%0d]: got %0b want 0", i, timer_irq);
            end
        end
        tick();
        tests_run++;
        if (timer_irq !== 1'b1 || req !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmr_hit: got irq=%0b req=%0b want 1/0", timer_irq, req);
        end
        tick();
        rd(5'd13, d);
        tests_run++;
        if (req !== 1'b1 || d !== 32'h0000_8010) begin
            tests_failed++; $display("FAIL tmr_ip: got req=%0b cause=%h want 1/8010", req, d);
        end
        tick();
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0000_8000 || exl_out !== 1'b1) begin
            tests_failed++; $display("FAIL tmr_take: got cause=%h exl=%0b want 8000/1", d, exl_out);
        end
        wr(5'd11, 32'h0000_0100);
        tests_run++;
        if (timer_irq !== 1'b0) begin tests_failed++; $display("FAIL tmr_ack: got %0b want 0", timer_irq); end
        tick();
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL tmr_ipclr: got %h want 0", d); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        wr(5'd12, 32'h0);
    endtask

    task automatic test_small_build();
        s_hw = 2'b11;
        tick();
        s_addr = 5'd13;
        #1;
        tests_run++;
        if (s_rdata !== 32'h0000_0C00) begin
            tests_failed++; $display("FAIL small_ip: got %h want c00", s_rdata);
        end
        s_addr = 5'd9;
        #1;
        tests_run++;
        if (s_rdata !== 32'h0 || s_tirq !== 1'b0) begin
            tests_failed++; $display("FAIL small_count: got %h tirq=%0b want 0/0", s_rdata, s_tirq);
        end
        s_exc = {5'd12, 20'd0};
        #1;
        tests_run++;
        if (s_req !== 1'b1) begin tests_failed++; $display("FAIL small_req: got %0b want 1", s_req); end
        tick();
        s_exc  = '0;
        s_addr = 5'd13;
        #1;
        tests_run++;
        if (s_rdata !== 32'h0000_0C30 || s_exl !== 1'b1) begin
            tests_failed++;
            $display("FAIL small_cause: got %h exl=%0b want c30/1", s_rdata, s_exl);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        hw_int = 6'b000001;
        vpc    = 32'h0000_6000;
        wr(5'd12, 32'h0000_0401);
        tick();
        exc_stage = 20'd8;
        reset     = 1'b0;
        #1;
        tests_run++;
        if (req !== 1'b0 || exl_out !== 1'b0 || s_exl !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_outs: got req=%0b exl=%0b s_exl=%0b want 0/0/0", req, exl_out, s_exl);
        end
        rd(5'd12, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mid_sr: got %h want 0", d); end
        rd(5'd13, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mid_cause: got %h want 0", d); end
        rd(5'd14, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mid_epc: got %h want 0", d); end
        tick();
        rd(5'd11, d);
        tests_run++;
        if (d !== 32'hFFFF_FFFF || req !== 1'b0) begin
            tests_failed++; $display("FAIL mid_compare: got %h req=%0b want ffffffff/0", d, req);
        end
        rd(5'd9, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mid_count: got %h want 0", d); end
        exc_stage = '0;
        hw_int    = '0;
        reset     = 1'b1;
        tick();
        rd(5'd9, d);
        tests_run++;
        if (d !== 32'h1) begin tests_failed++; $display("FAIL mid_restart: got %h want 1", d); end
    endtask

    initial begin
        reset     = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        vpc       = '0;
        bd_in     = 1'b0;
        exc_stage = '0;
        hw_int    = '0;
        eret      = 1'b0;
        s_we      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_vpc     = '0;
        s_bd      = 1'b0;
        s_exc     = '0;
        s_hw      = '0;
        s_eret    = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_regs();
        test_exception();
        test_eret();
        test_interrupt();
        test_write_lost();
        test_timer();
        test_small_build();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
